// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_pkg
//  Description : Shared types and helpers for the scanning channel selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

   // Controller states: single-shot/idle and automatic scan
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Ceiling log2, used for the select/index width (n >= 2 expected)
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sel_mux
//  Description : Combinational channel selector. Out-of-range indices return
//                all-zero data and raise o_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sel_mux
   import mux_scan_pkg::*;
#(
   parameter  int WIDTH    = 1,
   parameter  int CHANNELS = 8,
   localparam int SELW     = clog2(CHANNELS)
) (
   input  logic [CHANNELS*WIDTH-1:0] i_d,
   input  logic [SELW-1:0]           i_idx,
   output logic [WIDTH-1:0]          o_data,
   output logic                      o_err
);

   // Pick channel i_idx; an index matching no channel leaves zero data and err
   always_comb begin
      o_data = '0;
      o_err  = 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
         if (i_idx == SELW'(k)) begin
            o_data = i_d[k*WIDTH +: WIDTH];
            o_err  = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sel
//  Description : Registered channel selector with single-shot capture and an
//                automatic (optionally wrapping) channel scan, valid/ready
//                output handshake and tri-state true/inverted data outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sel
   import mux_scan_pkg::*;
#(
   parameter  int WIDTH    = 1,
   parameter  int CHANNELS = 8,
   localparam int SELW     = clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic [SELW-1:0]           sel_in,
   input  logic                      sel_load,
   input  logic                      scan_start,
   input  logic                      scan_stop,
   input  logic                      scan_cont,
   input  logic [SELW-1:0]           scan_first,
   input  logic [SELW-1:0]           scan_last,
   input  logic                      g_n,
   input  logic                      out_ready,
   inout  wire  [WIDTH-1:0]          y,
   inout  wire  [WIDTH-1:0]          w,
   output logic                      out_valid,
   output logic [SELW-1:0]           out_chan,
   output logic                      busy,
   output logic                      sel_err
);

   localparam logic [SELW-1:0] C_LAST_CH = SELW'(CHANNELS - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SELW-1:0]   r_ptr;
   logic [SELW-1:0]   r_first;
   logic [SELW-1:0]   r_last;
   logic              r_cont;
   logic [WIDTH-1:0]  r_data;
   logic [SELW-1:0]   r_chan;
   logic              r_valid;
   logic              r_err;

   logic              w_free;
   logic              w_cap;
   logic              w_latch;
   logic [SELW-1:0]   w_idx;
   logic [SELW-1:0]   w_ptr_nxt;
   logic [WIDTH-1:0]  w_mux_data;
   logic              w_mux_err;

   // Output slot can take a new sample when empty or being drained this cycle
   assign w_free = ~r_valid | out_ready;

   mux_scan_sel_mux #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_mux (
      .i_d    (d),
      .i_idx  (w_idx),
      .o_data (w_mux_data),
      .o_err  (w_mux_err)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state, capture decision and pointer advance
   always_comb begin
      w_state_nxt = r_state;
      w_cap       = 1'b0;
      w_latch     = 1'b0;
      w_idx       = sel_in;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            // A scan start takes priority over a simultaneous single-shot load
            if (scan_start) begin
               w_state_nxt = SCAN;
               w_latch     = 1'b1;
               w_ptr_nxt   = scan_first;
            end else if (sel_load && w_free) begin
               w_cap = 1'b1;
            end
         end
         SCAN: begin
            w_idx = r_ptr;
            if (w_free) begin
               w_cap = 1'b1;
               if (r_ptr == r_last) begin
                  w_ptr_nxt = r_first;
                  if (!r_cont) w_state_nxt = IDLE;
               end else if (r_ptr == C_LAST_CH) begin
                  w_ptr_nxt = '0;
               end else begin
                  w_ptr_nxt = r_ptr + 1'b1;
               end
            end
            // Abort still lets this cycle's capture complete
            if (scan_stop) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pointer, latched scan bounds and output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr   <= '0;
         r_first <= '0;
         r_last  <= '0;
         r_cont  <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ptr <= w_ptr_nxt;
         if (w_latch) begin
            r_first <= scan_first;
            r_last  <= scan_last;
            r_cont  <= scan_cont;
         end
         if (w_cap) begin
            r_data  <= w_mux_data;
            r_chan  <= w_idx;
            r_err   <= w_mux_err;
            r_valid <= 1'b1;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_chan  = r_chan;
   assign sel_err   = r_err;
   assign busy      = (r_state == SCAN);

   // Output enable only gates the pins; it never touches the held sample
   assign y = g_n ? {WIDTH{1'bz}} : ~r_data;
   assign w = g_n ? {WIDTH{1'bz}} :  r_data;

endmodule
`default_nettype wire

// File: doc/mux_scan_sel.md
MUX_SCAN_SEL -- requirements
Module: mux_scan_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per data channel.
REQ-002 SHALL have parameter CHANNELS, default 8: number of input channels, range 2..256.
REQ-003 SHALL have derived constant SELW = clog2(CHANNELS): select and channel-index width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  async active-low reset.
REQ-005 SHALL have port d  input  CHANNELS*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port sel_in  input  SELW  single-shot channel select.
REQ-007 SHALL have port sel_load  input  1  single-shot capture request.
REQ-008 SHALL have port scan_start  input  1  scan start pulse.
REQ-009 SHALL have port scan_stop  input  1  scan abort.
REQ-010 SHALL have port scan_cont  input  1  1 = wrap continuously, 0 = stop after scan_last.
REQ-011 SHALL have ports scan_first and scan_last  input  SELW each  scan bounds, sampled at scan_start.
REQ-012 SHALL have port g_n  input  1  active-low output enable.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the sample.
REQ-014 SHALL have ports y and w  inout  WIDTH each  y = inverted sample, w = true sample, high-Z when g_n=1.
REQ-015 SHALL have port out_valid  output  1  sample held in output register.
REQ-016 SHALL have port out_chan  output  SELW  channel index of the held sample.
REQ-017 SHALL have ports busy  output  1  (state SCAN) and sel_err  output  1  (held sample came from an index >= CHANNELS).

Function
REQ-018 SHALL implement states IDLE and SCAN.
REQ-019 Output slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-020 IDLE, sel_load=1, slot free: at the edge, data_reg <= d[sel_in], out_chan <= sel_in, out_valid <= 1 (1-cycle latency); if the slot is not free, sel_load is dropped.
REQ-021 IDLE, scan_start=1: at the edge, ptr <= scan_first, latch scan_first/scan_last/scan_cont, go to SCAN; scan_start wins over a simultaneous sel_load.
REQ-022 SCAN, slot free: capture d[ptr] into data_reg, out_chan <= ptr, out_valid <= 1, one channel per cycle at full throughput.
REQ-023 Pointer advance: if ptr = latched last, ptr <= latched first; else if ptr = CHANNELS-1, ptr <= 0; else ptr <= ptr+1. This permits first > last (wrap through 0).
REQ-024 Scan termination: capture of the latched last channel with scan_cont=0 returns to IDLE.
REQ-025 SCAN, slot not free: hold ptr and state, no capture (back-pressure).
REQ-026 scan_stop=1 in SCAN: go to IDLE at the edge; a capture eligible in that same cycle still completes; sel_load is ignored while in SCAN.
REQ-027 out_valid SHALL clear at the edge where out_valid=1, out_ready=1 and no new capture occurs.
REQ-028 Index >= CHANNELS: captured data SHALL be all-zero and sel_err SHALL be 1 for that sample.
REQ-029 y = ~data_reg and w = data_reg, combinationally driven whenever g_n=0, independent of out_valid; g_n SHALL NOT affect the state machine.

Reset
REQ-030 reset_n=0 SHALL asynchronously force: state IDLE, ptr 0, data_reg 0, out_chan 0, out_valid 0, sel_err 0, busy 0; y/w follow g_n with data_reg=0.
REQ-031 Reset mid-scan SHALL discard the scan and the held sample; the first edge after release behaves as IDLE.

Structure
REQ-032 Shared package mux_scan_pkg SHALL hold the state enum (IDLE, SCAN) and the clog2 helper.
REQ-033 Combinational channel select SHALL be sub-module mux_scan_sel_mux (parametrised WIDTH/CHANNELS, index in, data out, err out); the FSM, pointer, and output register stay in the top module.

Verification
REQ-034 WIDTH=4, CHANNELS=8, d[k]=k, sel_in=5, sel_load one cycle, out_ready=0 -> next cycle out_valid=1, w=4'h5, y=4'hA, out_chan=5; values hold until out_ready.
REQ-035 scan_first=2, scan_last=5, scan_cont=0, out_ready=1 -> out_chan 2,3,4,5 on consecutive cycles, then busy=0 and out_valid=0.
REQ-036 scan_first=6, scan_last=1, scan_cont=1 -> out_chan 6,7,0,1,6,7,... until scan_stop; IDLE the cycle after.
REQ-037 Same scan, out_ready low for 3 cycles on channel 3 -> out_chan stays 3 for 4 cycles, no channel skipped.
REQ-038 CHANNELS=6, sel_in=7 -> w=0, sel_err=1; g_n=1 -> y and w read Z.
REQ-039 reset_n pulsed low mid-scan between edges -> out_valid, busy, and data_reg clear immediately, without a clock edge.
